// File: rtl/alu_serial_arbiter.sv
// Round-robin arbiter that shares one external 1-bit ALU slice between two
// requesters, streaming operands LSB-first and assembling a W-bit result.
module alu_serial_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req0_x,
    input  logic [W-1:0] req0_y,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req1_x,
    input  logic [W-1:0] req1_y,
    output logic         req1_ready,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic         busy,
    output logic         alu_m,
    output logic         alu_s1,
    output logic         alu_s0,
    output logic [1:0]   alu_a,
    input  logic         alu_result
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_e;

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  y_q, y_d;
    logic          id_q, id_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  res_q, res_d;
    logic [W-1:0]  rdata_q, rdata_d;
    logic          rid_q, rid_d;
    logic          win;
    logic          run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            res_q   <= '0;
            rdata_q <= '0;
            rid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rdata_q <= rdata_d;
            rid_q   <= rid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        id_d    = id_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rdata_d = rdata_q;
        rid_d   = rid_q;
        win     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie the requester not granted last time wins
                    win     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
                    op_d    = win ? req1_op : req0_op;
                    x_d     = win ? req1_x : req0_x;
                    y_d     = win ? req1_y : req0_y;
                    id_d    = win;
                    last_d  = win;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                res_d[cnt_q] = alu_result;
                if (cnt_q == LAST) begin
                    rdata_d = res_d;
                    rid_d   = id_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign run        = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign req0_ready = (state_q == GRANT) && !id_q;
    assign req1_ready = (state_q == GRANT) && id_q;
    assign rsp_valid  = (state_q == DONE);
    assign rsp_id     = rid_q;
    assign rsp_data   = rdata_q;
    assign {alu_m, alu_s1, alu_s0} = run ? op_q : 3'b000;
    assign alu_a = run ? {x_q[cnt_q], y_q[cnt_q]} : 2'b00;

endmodule

// File: tb/tb_alu_serial_arbiter.sv
// Randomized and directed bench for alu_serial_arbiter with a word-level
// reference model and a behavioural 1-bit ALU.
module tb_alu_serial_arbiter;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_x, req0_y, req1_x, req1_y;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_id;
    logic [W-1:0] rsp_data;
    logic         busy;
    logic         alu_m, alu_s1, alu_s0;
    logic [1:0]   alu_a;
    logic         alu_result;

    int  n_vec = 0;
    int  n_bad = 0;
    bit  last = 1'b1;

    alu_serial_arbiter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op),
        .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op),
        .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .alu_m(alu_m), .alu_s1(alu_s1), .alu_s0(alu_s0),
        .alu_a(alu_a), .alu_result(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic alu_bit(logic [2:0] op, logic x, logic y);
        case (op)
            3'd0, 3'd4: return x;
            3'd1, 3'd5: return ~x;
            3'd2, 3'd6: return x ^ y;
            3'd3:       return ~(x ^ y);
            default:    return ~x ^ y;
        endcase
    endfunction

    assign alu_result = alu_bit({alu_m, alu_s1, alu_s0}, alu_a[1], alu_a[0]);

    function automatic logic [W-1:0] alu_word(logic [2:0] op,
                                              logic [W-1:0] x,
                                              logic [W-1:0] y);
        case (op)
            3'd0, 3'd4: return x;
            3'd1, 3'd5: return ~x;
            3'd2, 3'd6: return x ^ y;
            3'd3:       return ~(x ^ y);
            default:    return ~x ^ y;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ctl"}, {req0_ready, req1_ready, rsp_valid, rsp_id, busy,
                            alu_m, alu_s1, alu_s0, alu_a}, 0);
        chk({tag, "_data"}, rsp_data, 0);
    endtask

    task automatic serve(input bit v0, input bit v1,
                         input logic [2:0] o0, input logic [2:0] o1,
                         input logic [W-1:0] x0, input logic [W-1:0] y0,
                         input logic [W-1:0] x1, input logic [W-1:0] y1,
                         input bit gl0);
        int q[$];
        int c, rc, cur, i;
        bit first;
        logic [2:0]   os[2];
        logic [W-1:0] xs[2];
        logic [W-1:0] ys[2];
        os[0] = o0; os[1] = o1;
        xs[0] = x0; xs[1] = x1;
        ys[0] = y0; ys[1] = y1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        if (v0 && v1) q = last ? '{0, 1} : '{1, 0};
        else if (v0) q = '{0};
        else q = '{1};
        req0_valid = v0; req0_op = o0; req0_x = x0; req0_y = y0;
        req1_valid = v1; req1_op = o1; req1_x = x1; req1_y = y1;
        c = 0; rc = 0; cur = -1; first = 1'b1;
        while (q.size() > 0 && c < 4 * (W + 3)) begin
            @(negedge clk);
            c++;
            if (gl0 && c == 4) begin
                req0_valid = 1'b1;
                req0_op = 3'b010;
            end
            if (gl0 && c == 6) req0_valid = 1'b0;
            if (req0_ready || req1_ready) begin
                cur = req1_ready ? 1 : 0;
                chk("one_ready", {req0_ready, req1_ready}, cur == 1 ? 2'b01 : 2'b10);
                chk("grant_id", cur, q[0]);
                if (first) chk("arb_lat", c, 1);
                first = 1'b0;
                chk("busy_grant", busy, 1);
                chk("alu_idle", {alu_m, alu_s1, alu_s0, alu_a}, 0);
                rc = c;
                last = cur[0];
                if (cur == 0) req0_valid = 1'b0;
                else req1_valid = 1'b0;
            end else if (cur >= 0 && c > rc && c <= rc + W) begin
                i = c - rc - 1;
                chk("alu_a", alu_a, {xs[cur][i], ys[cur][i]});
                chk("alu_op", {alu_m, alu_s1, alu_s0}, os[cur]);
                chk("busy_run", busy, 1);
            end
            if (rsp_valid) begin
                chk("rsp_id", rsp_id, q[0]);
                chk("rsp_data", rsp_data, alu_word(os[q[0]], xs[q[0]], ys[q[0]]));
                chk("rsp_lat", c - rc, W + 1);
                chk("alu_done", alu_a, 0);
                void'(q.pop_front());
                cur = -1;
            end
        end
        if (q.size() > 0) chk("timeout", q.size(), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("quiet", {rsp_valid, req0_ready, req1_ready, busy}, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        last = 1'b1;
    endtask

    task automatic mid_reset();
        int c;
        @(negedge clk);
        req1_valid = 1'b1; req1_op = 3'b010;
        req1_x = 8'h5A; req1_y = 8'hC3;
        c = 0;
        while (!req1_ready && c < 8) begin
            @(negedge clk);
            c++;
        end
        chk("mr_ready", req1_ready, 1);
        repeat (4) @(negedge clk);
        chk("mr_busy", busy, 1);
        rst_n = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk_zero_outputs("mr");
        @(negedge clk);
        chk("mr_norsp", {rsp_valid, req1_ready}, 0);
        rst_n = 1'b1;
        last = 1'b1;
    endtask

    initial begin
        logic [1:0] v;
        rst_n = 1'b0;
        req0_valid = 0; req0_op = 0; req0_x = 0; req0_y = 0;
        req1_valid = 0; req1_op = 0; req1_x = 0; req1_y = 0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        serve(1, 0, 3'b010, 3'b000, 8'hA5, 8'h3C, 8'h00, 8'h00, 0);
        serve(0, 1, 3'b000, 3'b011, 8'h00, 8'h00, 8'hA5, 8'h3C, 0);
        serve(0, 1, 3'b000, 3'b001, 8'h00, 8'h00, 8'hA5, 8'h00, 0);
        serve(0, 1, 3'b000, 3'b111, 8'h00, 8'h00, 8'hF0, 8'h0F, 0);

        do_reset();
        serve(1, 1, 3'b000, 3'b000, 8'h12, 8'h00, 8'h34, 8'h00, 0);
        serve(1, 1, 3'b000, 3'b000, 8'h12, 8'h00, 8'h34, 8'h00, 0);

        serve(1, 0, 3'b110, 3'b000, 8'h0F, 8'hFF, 8'h00, 8'h00, 0);
        serve(0, 1, 3'b000, 3'b010, 8'h00, 8'h00, 8'h77, 8'h21, 1);

        mid_reset();
        serve(0, 1, 3'b000, 3'b010, 8'h00, 8'h00, 8'h5A, 8'hC3, 0);

        for (int k = 0; k < 30; k++) begin
            v = 2'($urandom_range(1, 3));
            serve(v[0], v[1], 3'($urandom), 3'($urandom),
                  W'($urandom), W'($urandom), W'($urandom), W'($urandom), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_serial_arbiter.md
Name: alu_serial_arbiter

Overview:
- Shares one 1-bit, 2-input mode-select ALU slice between two requesters.
- Each requester submits an opcode {M,S1,S0} and two W-bit operands.
- The block arbitrates round-robin, streams the operands through the ALU LSB-first one bit per cycle, assembles the W-bit result, and returns it to the winning requester.
- Sits between requester logic and the existing combinational ALU, which is instantiated outside this block.

Parameters:
W, 8, operand/result width in bits; legal W >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 request; held until req0_ready
req0_op  input  3  requester 0 opcode {M,S1,S0}
req0_x  input  W  requester 0 operand X (drives ALU A[1])
req0_y  input  W  requester 0 operand Y (drives ALU A[0])
req0_ready  output  1  1-cycle accept pulse to requester 0
req1_valid, req1_op, req1_x, req1_y, req1_ready  same as requester 0, for requester 1
rsp_valid  output  1  1-cycle result pulse
rsp_id  output  1  requester that owns rsp_data
rsp_data  output  W  assembled result
busy  output  1  high in GRANT, RUN and DONE
alu_m, alu_s1, alu_s0  output  1 each  opcode to ALU
alu_a  output  2  {X[i], Y[i]} for the current bit i
alu_result  input  1  combinational ALU output for alu_a

Behaviour:
- ALU function (bench model): 000 X; 001 ~X; 010 X^Y; 011 ~(X^Y); 100 X; 101 ~X; 110 X^Y (1-bit sum); 111 ~X^Y.
- FSM states: IDLE, GRANT, RUN, DONE. Reset state is IDLE.
- Reset values: all outputs 0, bit counter 0, last_grant=1 (requester 0 wins the first tie), operand/result registers 0.
- IDLE:
  - If any reqN_valid is high, pick a winner.
  - Single requester: that one wins.
  - Both requesting: the one that is not last_grant wins.
  - Register the winner's op, x, y and id; set last_grant to the winner; go to GRANT.
- GRANT (1 cycle):
  - reqN_ready=1 for the winner only; the loser sees no ready.
  - Clear the counter; go to RUN.
- RUN (exactly W cycles, i=0..W-1):
  - alu_m/s1/s0 = latched op.
  - alu_a = {x[i], y[i]}, driven from registers/counter so it is stable for the whole cycle.
  - At each rising edge, result[i] <= alu_result and the counter increments.
  - After the edge capturing i=W-1, go to DONE.
- DONE (1 cycle):
  - rsp_valid=1, rsp_id=winner, rsp_data=result.
  - Go to IDLE.
  - rsp_data and rsp_id hold their values until the next DONE. rsp_valid is low outside DONE.
- ALU outputs outside RUN: alu_a=0 and opcode=000.
- Latency:
  - Arbitration edge = T.
  - req_ready is high in cycle T+1.
  - rsp_valid is high in cycle T+W+2.
  - Throughput is one operation per W+3 cycles.
- Requests are not queued.
  - Requests are sampled only in IDLE.
  - A request dropped before its ready pulse is simply never served.
  - Inputs are ignored while busy; the loser keeps valid asserted and is served next.
- A requester may reassert valid in the cycle after its ready. It then competes round-robin, so it loses a tie.
- Counter width is clog2(W). It saturates at the DONE transition and never wraps into a new RUN.
- Reset asserted mid-operation:
  - Immediate return to IDLE with reset values.
  - The in-flight operation is discarded; no rsp_valid, no ready pulse.
  - last_grant returns to 1.

Test Plan:
- Reset, req0 op=010 x=0xA5 y=0x3C (W=8) -> req0_ready one cycle after arbitration; rsp_valid 10 cycles after arbitration edge with rsp_id=0, rsp_data=0x99; busy high GRANT..DONE.
- req1 op=011 x=0xA5 y=0x3C -> rsp_id=1, rsp_data=0x66. Then op=001 x=0xA5 -> 0x5A. Then op=111 x=0xF0 y=0x0F -> 0x00.
- Round-robin:
  - Right after reset, both valid (req0 op=000 x=0x12; req1 op=000 x=0x34) -> req0 served first (0x12).
  - req1 served second (0x34) without its valid dropping.
  - Both reassert -> req0 wins (last_grant=1).
- RUN-cycle alu_a check for op=110 x=0x0F y=0xFF:
  - alu_a per RUN cycle = 11,11,11,11,01,01,01,01; opcode pins stay at 110 throughout.
  - rsp_data=0xF0.
- req0 valid pulsed while busy serving req1, dropped before IDLE -> never granted, no req0_ready, only one rsp_valid.
- rst_n low at RUN bit 3 -> all outputs 0 asynchronously, no rsp_valid. After release, a new req1 request completes normally with a correct result.
